winograd_layer_sequencer: RTL
=============================

# winograd_layer_sequencer

Sequences one convolution layer through the input-transform data controller: iterates the input-channel id from 0 to N-1, fires one prepare pulse per channel, waits for the controller's address loop to finish, counts the transformed tiles delivered to the PE arrays, and waits for the PE arrays to drain before starting the next channel. It sits between the main controller and the input data controller, and holds layer geometry stable for the whole layer.

## Interface

- `ID_W`, 4: channel-id width; at most 2^ID_W channels per layer.
- `DIM_W`, 8: block width/height width.

Ports:

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start_i` in 1: single-cycle layer start request.
- `num_channels_i` in ID_W+1: channel count, 1..2^ID_W; sampled on accepted start.
- `block_width_i`, `block_height_i` in DIM_W each: tile grid dimensions; sampled on accepted start.
- `size_type_i` in 1: tile size type; sampled on accepted start.
- `busy_o` out 1: high from the accepted start until DONE exits.
- `layer_done_o` out 1: one-cycle pulse when the layer completes.
- `error_o` out 1: sticky error flag.
- `input_id_o` out ID_W: current channel id, to the data controller.
- `input_prepare_o` out 1: one-cycle prepare pulse, to the data controller.
- `block_width_o`, `block_height_o` out DIM_W each: latched geometry.
- `size_type_o` out 1: latched size type.
- `loop_finished_i` in 1: address-loop finished, from the data controller.
- `data_valid_i` in 1: one transformed tile pair delivered to the PE arrays.
- `pe_ready_i` in 1: PE arrays have drained and accept the next channel.
- `beat_cnt_o` out 8: tile-pair beats counted for the current channel.

## Operation

- States: IDLE, PREP, STREAM, DRAIN, NEXT, DONE.
- **IDLE.** `start_i` is checked against the configuration. It is a config error if `num_channels_i` is 0 or greater than 2^ID_W, if width×height is 0, or if width×height is greater than 255.
  - On a config error: set `error_o`, stay in IDLE.
  - Otherwise: latch all configuration inputs, clear `error_o`, set `input_id_o`=0, go to PREP.
- **PREP.** Assert `input_prepare_o` for exactly 1 cycle, clear `beat_cnt_o`, go to STREAM.
- **STREAM.** Wait for `loop_finished_i`=1, then go to DRAIN. `loop_finished_i` is ignored in every other state.
- **DRAIN.** Exit when `beat_cnt_o` == expected and `pe_ready_i`=1, then go to NEXT.
  - Expected beats = (width×height+1)>>1, computed with a 16-bit product; the odd last tile is carried alone.
- **NEXT.**
  - If `input_id_o` == latched N−1: go to DONE.
  - Else: increment `input_id_o`, go to PREP.
- **DONE.** Pulse `layer_done_o` for 1 cycle, go to IDLE.
- **Beat counting.** `beat_cnt_o` increments on every `data_valid_i` in STREAM or DRAIN.
  - A beat arriving when `beat_cnt_o` already equals expected sets `error_o`; the counter saturates.
  - `data_valid_i` in IDLE, PREP or DONE sets `error_o`.
- `start_i` while `busy_o`=1 is ignored.
- `error_o` clears only on an accepted, valid start.
- Outputs `block_width_o`, `block_height_o`, `size_type_o` and `input_id_o` hold their values after DONE until the next accepted start.

## Timing

- Reset values: state IDLE; all outputs 0.
- Start to first `input_prepare_o`: 1 cycle. The start is registered in the IDLE→PREP cycle and the prepare pulse occurs the next cycle.
- The data controller raises `loop_finished_i` roughly ceil(blocks/2) cycles after prepare. `data_valid_i` trails its addresses by 3 cycles, so beats keep arriving in DRAIN.
- Beat and exit in the same cycle:
  - A beat arriving while `pe_ready_i`=1 is counted first.
  - DRAIN exits on the following cycle once the count equals expected.
- NEXT to the following PREP: 1 cycle. Channel-to-channel overhead is PREP + NEXT + DRAIN wait.
- `busy_o` falls in the cycle after the `layer_done_o` pulse.
- Asynchronous reset mid-layer returns the block to IDLE immediately and clears all outputs. No `layer_done_o` is produced.

## Configuration

- `SEQ_WATCHDOG_EN` defined:
  - An 8-bit counter runs in DRAIN. It resets on every `data_valid_i` and on entering DRAIN.
  - If it reaches 255 with expected beats not yet reached: set `error_o`, deassert `busy_o`, return to IDLE without `layer_done_o`.
- Not defined: DRAIN waits indefinitely and no watchdog logic is present.

## Test plan

- **Normal layer.** N=2, 4×3 grid, `pe_ready_i`=1, model controller returns 6 beats per channel.
  - Required: prepare pulses with `input_id_o`=0 then 1, `beat_cnt_o` reaches 6 each time, one `layer_done_o`, `error_o`=0.
- **Odd block count.** 3×3 grid, N=1.
  - Required: expected beats = 5; DRAIN exits only after the 5th beat.
- **Backpressure.** `pe_ready_i` held 0 for 20 cycles after the last beat.
  - Required: state stays DRAIN, no prepare pulse, then NEXT one cycle after `pe_ready_i` rises.
- **Config errors.**
  - `num_channels_i`=0: `error_o`=1, `busy_o` stays 0.
  - 16×16 grid: rejected in the same way.
  - A subsequent valid start clears `error_o`.
- **Extra beat and start while busy.**
  - 7th beat for a 6-beat channel sets `error_o`.
  - `start_i` mid-layer is ignored.
  - Reset during STREAM gives all outputs 0 in the same cycle.
- **Watchdog (`SEQ_WATCHDOG_EN` defined).** Stop beats at 3 of 6.
  - Required: after 255 cycles `error_o`=1, `busy_o`=0, no `layer_done_o`.

Source files
------------

// File: rtl/winograd_layer_sequencer.sv
// Per-layer channel sequencer for the Winograd input-transform data controller.
// Optional DRAIN watchdog is compiled in when SEQ_WATCHDOG_EN is defined.
module winograd_layer_sequencer #(
  parameter int ID_W  = 4,
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [ID_W:0]    num_channels_i,
  input  logic [DIM_W-1:0] block_width_i,
  input  logic [DIM_W-1:0] block_height_i,
  input  logic             size_type_i,
  output logic             busy_o,
  output logic             layer_done_o,
  output logic             error_o,
  output logic [ID_W-1:0]  input_id_o,
  output logic             input_prepare_o,
  output logic [DIM_W-1:0] block_width_o,
  output logic [DIM_W-1:0] block_height_o,
  output logic             size_type_o,
  input  logic             loop_finished_i,
  input  logic             data_valid_i,
  input  logic             pe_ready_i,
  output logic [7:0]       beat_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_STREAM, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  localparam logic [ID_W:0] MAX_CH = {1'b1, {ID_W{1'b0}}};
  localparam logic [ID_W:0] ONE_CH = {{ID_W{1'b0}}, 1'b1};

  state_t           state_q;
  logic             busy_q, layer_done_q, error_q, prepare_q, size_type_q;
  logic [ID_W-1:0]  input_id_q;
  logic [ID_W:0]    num_ch_q;
  logic [DIM_W-1:0] block_width_q, block_height_q;
  logic [7:0]       beat_cnt_q, expected_q;
`ifdef SEQ_WATCHDOG_EN
  logic [7:0]       wdog_q;
`endif

  logic [15:0] area_d;
  logic        cfg_err_d;
  logic [7:0]  exp_beats_d;
  logic        beats_full_d;
  logic        last_ch_d;

  // Tiles travel in pairs; an odd last tile is carried alone, hence ceil(area/2).
  assign area_d       = 16'(block_width_i) * 16'(block_height_i);
  assign cfg_err_d    = (num_channels_i == '0) || (num_channels_i > MAX_CH) ||
                        (area_d == 16'd0) || (area_d > 16'd255);
  assign exp_beats_d  = {1'b0, area_d[7:1]} + {7'd0, area_d[0]};
  assign beats_full_d = (beat_cnt_q == expected_q);
  assign last_ch_d    = ({1'b0, input_id_q} == (num_ch_q - ONE_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      layer_done_q   <= 1'b0;
      error_q        <= 1'b0;
      prepare_q      <= 1'b0;
      size_type_q    <= 1'b0;
      input_id_q     <= '0;
      num_ch_q       <= '0;
      block_width_q  <= '0;
      block_height_q <= '0;
      beat_cnt_q     <= '0;
      expected_q     <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q         <= '0;
`endif
    end else begin
      prepare_q    <= 1'b0;
      layer_done_q <= 1'b0;

      // Beats belong to STREAM/DRAIN; elsewhere (except NEXT) they are a protocol error.
      if (data_valid_i) begin
        if (state_q == S_STREAM || state_q == S_DRAIN) begin
          if (beats_full_d) error_q <= 1'b1;
          else              beat_cnt_q <= beat_cnt_q + 8'd1;
        end else if (state_q != S_NEXT) begin
          error_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_err_d) begin
              error_q <= 1'b1;
            end else begin
              num_ch_q       <= num_channels_i;
              block_width_q  <= block_width_i;
              block_height_q <= block_height_i;
              size_type_q    <= size_type_i;
              expected_q     <= exp_beats_d;
              error_q        <= 1'b0;
              input_id_q     <= '0;
              beat_cnt_q     <= '0;
              busy_q         <= 1'b1;
              prepare_q      <= 1'b1;
              state_q        <= S_PREP;
            end
          end
        end
        S_PREP: state_q <= S_STREAM;
        S_STREAM: begin
          if (loop_finished_i) begin
            state_q <= S_DRAIN;
`ifdef SEQ_WATCHDOG_EN
            wdog_q  <= '0;
`endif
          end
        end
        S_DRAIN: begin
          if (beats_full_d && pe_ready_i) state_q <= S_NEXT;
`ifdef SEQ_WATCHDOG_EN
          if (data_valid_i) begin
            wdog_q <= '0;
          end else if (wdog_q == 8'd255) begin
            if (!beats_full_d) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        S_NEXT: begin
          if (last_ch_d) begin
            layer_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            input_id_q <= input_id_q + ID_W'(1);
            beat_cnt_q <= '0;
            prepare_q  <= 1'b1;
            state_q    <= S_PREP;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign layer_done_o    = layer_done_q;
  assign error_o         = error_q;
  assign input_id_o      = input_id_q;
  assign input_prepare_o = prepare_q;
  assign block_width_o   = block_width_q;
  assign block_height_o  = block_height_q;
  assign size_type_o     = size_type_q;
  assign beat_cnt_o      = beat_cnt_q;

endmodule
